// File: rtl/g729_pkg.sv
// Shared G.729 definitions: post-filter coefficients, saturation limits, the post-filter
// FSM state type and ITU basic_op arithmetic used by the fixed-point datapaths.
package g729_pkg;

   localparam logic signed [15:0] B0 = 16'sd7699;
   localparam logic signed [15:0] B1 = -16'sd15398;
   localparam logic signed [15:0] B2 = 16'sd7699;
   localparam logic signed [15:0] A1 = 16'sd15836;
   localparam logic signed [15:0] A2 = -16'sd7667;

   localparam logic signed [31:0] MAX_32 = 32'sh7FFF_FFFF;
   localparam logic signed [31:0] MIN_32 = 32'sh8000_0000;
   localparam logic signed [15:0] MAX_16 = 16'sh7FFF;
   localparam logic signed [15:0] MIN_16 = 16'sh8000;

   typedef enum logic [3:0] {
      StIdle, StMac0, StMac1, StMac2, StMac3, StMac4, StMac5, StMac6, StFin, StOut
   } hpf_state_e;

   typedef enum logic [1:0] {MacLoad, MacAcc, MacAccMult} mac_mode_e;

   // Double-precision value: hi is Q31 >> 16, lo holds the next 15 bits.
   typedef struct packed {
      logic signed [15:0] hi;
      logic signed [15:0] lo;
   } dpf_t;

   function automatic logic signed [31:0] sat32(input logic signed [32:0] s);
      if (s > 33'sh0_7FFF_FFFF) return MAX_32;
      else if (s < 33'sh1_8000_0000) return MIN_32;
      else return s[31:0];
   endfunction

   function automatic logic signed [15:0] sat16(input logic signed [31:0] q);
      if (q > 32'sd32767) return MAX_16;
      else if (q < -32'sd32768) return MIN_16;
      else return q[15:0];
   endfunction

   function automatic logic signed [31:0] l_add(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
      logic signed [32:0] s;
      s = 33'(a) + 33'(b);
      return sat32(s);
   endfunction

   function automatic logic signed [31:0] l_mult(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
      logic signed [31:0] p;
      p = 32'(a) * 32'(b);
      if (p == 32'sh4000_0000) return MAX_32;
      else return p <<< 1;
   endfunction

   function automatic logic signed [15:0] mult(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
      logic signed [31:0] p;
      p = 32'(a) * 32'(b);
      return sat16(p >>> 15);
   endfunction

   function automatic logic signed [31:0] l_mac(input logic signed [31:0] l,
                                                input logic signed [15:0] a,
                                                input logic signed [15:0] b);
      return l_add(l, l_mult(a, b));
   endfunction

   function automatic logic signed [31:0] l_shl(input logic signed [31:0] l,
                                                input int unsigned n);
      logic signed [31:0] r;
      r = l;
      for (int unsigned i = 0; i < n; i++) begin
         if (r > 32'sh3FFF_FFFF) r = MAX_32;
         else if (r < 32'shC000_0000) r = MIN_32;
         else r = r <<< 1;
      end
      return r;
   endfunction

   function automatic logic signed [15:0] l_round(input logic signed [31:0] l);
      logic signed [31:0] r;
      r = l_add(l, 32'sh0000_8000);
      return r[31:16];
   endfunction

   function automatic dpf_t l_extract(input logic signed [31:0] l);
      dpf_t d;
      logic signed [31:0] t;
      d.hi = l[31:16];
      t = (l >>> 1) - (32'(d.hi) <<< 15);
      d.lo = t[15:0];
      return d;
   endfunction

endpackage

// File: rtl/g729_sat_mac.sv
// Registered 16x16 saturating multiply-accumulate: load L_mult, accumulate L_mac,
// or accumulate the 16-bit mult() product (DPF low-half terms).
module g729_sat_mac
   import g729_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  mac_mode_e          mode,
   input  logic signed [15:0] a,
   input  logic signed [15:0] b,
   output logic signed [31:0] acc
);

   logic signed [31:0] acc_d, acc_q;

   always_comb begin
      acc_d = acc_q;
      if (en) begin
         unique case (mode)
            MacLoad:    acc_d = l_mult(a, b);
            MacAcc:     acc_d = l_mac(acc_q, a, b);
            MacAccMult: acc_d = l_mac(acc_q, mult(a, b), 16'sd1);
            default:    acc_d = acc_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule

// File: rtl/post_proc_hpf.sv
// G.729 decoder post-processing: 2nd-order 100 Hz high-pass with x2 output gain,
// bit-exact, evaluated over seven MAC cycles on one shared saturating MAC.
module post_proc_hpf
   import g729_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_sample,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_sample
);

   hpf_state_e         state_q, state_d;
   logic signed [15:0] x0_q, x1_q, x2_q;
   logic signed [15:0] y1_hi_q, y1_lo_q, y2_hi_q, y2_lo_q;
   logic [15:0]        out_sample_q;
   logic               mac_en;
   mac_mode_e          mac_mode;
   logic signed [15:0] mac_a, mac_b;
   logic signed [31:0] acc;
   logic signed [31:0] l_q15;
   dpf_t               y_new;
   logic               accept;

   assign in_ready   = (state_q == StIdle);
   assign out_valid  = (state_q == StOut);
   assign out_sample = out_sample_q;
   // clear wins over a simultaneous accept
   assign accept     = in_ready & in_valid & ~clear;
   assign l_q15      = l_shl(acc, 2);
   assign y_new      = l_extract(l_q15);

   always_comb begin
      state_d  = state_q;
      mac_en   = 1'b0;
      mac_mode = MacLoad;
      mac_a    = '0;
      mac_b    = '0;
      unique case (state_q)
         StIdle: if (accept) state_d = StMac0;
         StMac0: begin
            mac_en = 1'b1; mac_mode = MacLoad;     mac_a = y1_hi_q; mac_b = A1; state_d = StMac1;
         end
         StMac1: begin
            mac_en = 1'b1; mac_mode = MacAccMult;  mac_a = y1_lo_q; mac_b = A1; state_d = StMac2;
         end
         StMac2: begin
            mac_en = 1'b1; mac_mode = MacAcc;      mac_a = y2_hi_q; mac_b = A2; state_d = StMac3;
         end
         StMac3: begin
            mac_en = 1'b1; mac_mode = MacAccMult;  mac_a = y2_lo_q; mac_b = A2; state_d = StMac4;
         end
         StMac4: begin
            mac_en = 1'b1; mac_mode = MacAcc;      mac_a = x0_q;    mac_b = B0; state_d = StMac5;
         end
         StMac5: begin
            mac_en = 1'b1; mac_mode = MacAcc;      mac_a = x1_q;    mac_b = B1; state_d = StMac6;
         end
         StMac6: begin
            mac_en = 1'b1; mac_mode = MacAcc;      mac_a = x2_q;    mac_b = B2; state_d = StFin;
         end
         StFin:  state_d = StOut;
         StOut:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         x0_q         <= '0;
         x1_q         <= '0;
         x2_q         <= '0;
         y1_hi_q      <= '0;
         y1_lo_q      <= '0;
         y2_hi_q      <= '0;
         y2_lo_q      <= '0;
         out_sample_q <= '0;
      end else begin
         state_q <= state_d;
         if (in_ready && clear) begin
            x0_q    <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            y1_hi_q <= '0;
            y1_lo_q <= '0;
            y2_hi_q <= '0;
            y2_lo_q <= '0;
         end else if (accept) begin
            x0_q <= $signed(in_sample);
         end else if (state_q == StFin) begin
            x2_q         <= x1_q;
            x1_q         <= x0_q;
            y2_hi_q      <= y1_hi_q;
            y2_lo_q      <= y1_lo_q;
            y1_hi_q      <= y_new.hi;
            y1_lo_q      <= y_new.lo;
            out_sample_q <= l_round(l_shl(l_q15, 1));
         end
      end
   end

   g729_sat_mac u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (mac_en),
      .mode  (mac_mode),
      .a     (mac_a),
      .b     (mac_b),
      .acc   (acc)
   );

endmodule

// File: tb/tb_post_proc_hpf.sv
// Self-checking bench for post_proc_hpf against a longint reference of the G.729
// Post_Process loop, with a queue of expected outputs.
module tb_post_proc_hpf;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_sample = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_sample;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   longint mx1, mx2, my1h, my1l, my2h, my2l;

   always #5 clk = ~clk;

   post_proc_hpf dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sample  (in_sample),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sample (out_sample)
   );

   // ---------------- reference model ----------------
   function automatic longint sat32(longint v);
      if (v > 64'sd2147483647) return 64'sd2147483647;
      if (v < -64'sd2147483648) return -64'sd2147483648;
      return v;
   endfunction

   function automatic longint sat16(longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic longint m_lmult(longint a, longint b);
      return sat32(2 * a * b);
   endfunction

   function automatic longint m_mult(longint a, longint b);
      return sat16((a * b) >>> 15);
   endfunction

   function automatic longint m_lmac(longint l, longint a, longint b);
      return sat32(l + m_lmult(a, b));
   endfunction

   function automatic longint m_shl(longint l, int n);
      return sat32(l * (64'sd1 << n));
   endfunction

   function automatic longint m_round(longint l);
      return sat32(l + 32768) >>> 16;
   endfunction

   task automatic model_reset();
      mx1 = 0; mx2 = 0; my1h = 0; my1l = 0; my2h = 0; my2l = 0;
   endtask

   task automatic model_step(input longint x0, output int y);
      longint l;
      l = m_lmult(my1h, 15836);
      l = m_lmac(l, m_mult(my1l, 15836), 1);
      l = m_lmac(l, my2h, -7667);
      l = m_lmac(l, m_mult(my2l, -7667), 1);
      l = m_lmac(l, x0, 7699);
      l = m_lmac(l, mx1, -15398);
      l = m_lmac(l, mx2, 7699);
      l = m_shl(l, 2);
      mx2 = mx1; mx1 = x0;
      my2h = my1h; my2l = my1l;
      my1h = l >>> 16;
      my1l = (l >>> 1) - my1h * 32768;
      y = int'(m_round(m_shl(l, 1)));
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one sample and wait for it to be taken; pushes the model's result.
   task automatic send(input int x);
      int  y;
      bit  done = 1'b0;
      in_valid  = 1'b1;
      in_sample = 16'(x);
      for (int c = 0; c < 200 && !done; c++) begin
         if (in_ready && !clear) begin
            model_step(longint'(signed'(16'(x))), y);
            exp_q.push_back(y);
            done = 1'b1;
         end
         tick();
      end
      in_valid = 1'b0;
      if (!done) begin
         errors++; checks++;
         $display("FAIL send_timeout: in_ready never seen, required 1");
      end
   endtask

   // Accept one output (out_ready held high) and compare with the queue head.
   task automatic recv(input string name);
      bit done = 1'b0;
      int e;
      out_ready = 1'b1;
      for (int c = 0; c < 200 && !done; c++) begin
         if (out_valid) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 99999;
            checks++;
            if ($signed(out_sample) !== e) begin
               errors++;
               $display("FAIL %s: out_sample=%0d required %0d", name, $signed(out_sample), e);
            end
            done = 1'b1;
         end
         tick();
      end
      out_ready = 1'b0;
      if (!done) begin
         errors++; checks++;
         $display("FAIL %s_timeout: out_valid never seen, required 1", name);
      end
   endtask

   task automatic zero_history();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_reset();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sample !== 16'h0000) begin
         errors++;
         $display("FAIL reset_state: rdy=%b vld=%b out=%h required 1 0 0000",
                  in_ready, out_valid, out_sample);
      end
      model_reset();
      send(1000);
      recv("reset_first");
      send(-5000);
      tick(); tick(); tick();  // now in MAC3
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sample !== 16'h0000) begin
         errors++;
         $display("FAIL reset_async: rdy=%b vld=%b out=%h required 1 0 0000",
                  in_ready, out_valid, out_sample);
      end
      void'(exp_q.pop_back());
      model_reset();
      tick();
      rst_n = 1'b1;
      tick();
      send(1000);
      recv("reset_history");
   endtask

   task automatic test_impulse();
      int n;
      int lit[2] = '{1880, -126};
      int xs[2]  = '{1000, 0};
      zero_history();
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1;
         in_sample = 16'(xs[k]);
         tick();  // accepting edge, counted as edge 1
         in_valid = 1'b0;
         n = 1;
         while (!out_valid && n < 50) begin
            tick();
            n++;
         end
         checks++;
         if (n !== 9) begin
            errors++;
            $display("FAIL impulse_latency%0d: edges=%0d required 9", k, n);
         end
         checks++;
         if ($signed(out_sample) !== lit[k]) begin
            errors++;
            $display("FAIL impulse_value%0d: out_sample=%0d required %0d",
                     k, $signed(out_sample), lit[k]);
         end
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
   endtask

   task automatic test_saturation();
      int y;
      zero_history();
      send(-32768);
      recv("sat_first");
      send(0);
      recv("sat_second");
      model_reset();
      model_step(-32768, y);
      // independent literal check of the saturated first output
      zero_history();
      send(-32768);
      out_ready = 1'b1;
      while (!out_valid) tick();
      checks++;
      if ($signed(out_sample) !== -32768) begin
         errors++;
         $display("FAIL sat_literal: out_sample=%0d required -32768", $signed(out_sample));
      end
      void'(exp_q.pop_front());
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int e;
      int cnt = 0;
      zero_history();
      send(3000);
      e = exp_q[0];
      while (!out_valid && cnt < 50) begin
         tick();
         cnt++;
      end
      for (int c = 0; c < 20; c++) begin
         in_valid  = c[0];
         in_sample = 16'(c * 777);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || $signed(out_sample) !== e) begin
            errors++;
            $display("FAIL bp_hold%0d: vld=%b rdy=%b out=%0d required 1 0 %0d",
                     c, out_valid, in_ready, $signed(out_sample), e);
         end
         tick();
      end
      in_valid = 1'b0;
      recv("bp_release");
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_after: vld=%b rdy=%b required 0 1", out_valid, in_ready);
      end
      send(-2000);
      recv("bp_next");
   endtask

   task automatic test_clear();
      zero_history();
      for (int k = 0; k < 5; k++) begin
         send(int'($urandom_range(0, 65535)) - 32768);
         recv("clear_pre");
      end
      clear = 1'b1;
      in_valid = 1'b1;
      in_sample = 16'd12345;
      tick();
      clear = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL clear_no_accept: rdy=%b vld=%b required 1 0", in_ready, out_valid);
      end
      model_reset();
      send(1000);
      recv("clear_after");
   endtask

   task automatic test_streaming();
      fork
         begin
            for (int i = 0; i < 2000; i++) begin
               repeat ($urandom_range(0, 2)) tick();
               send(int'($urandom_range(0, 65535)) - 32768);
            end
         end
         begin
            for (int i = 0; i < 2000; i++) begin
               bit done = 1'b0;
               int e;
               for (int c = 0; c < 400 && !done; c++) begin
                  out_ready = ($urandom_range(0, 2) != 0);
                  if (out_valid && out_ready) begin
                     e = (exp_q.size() != 0) ? exp_q.pop_front() : 99999;
                     checks++;
                     if ($signed(out_sample) !== e) begin
                        errors++;
                        $display("FAIL stream%0d: out_sample=%0d required %0d",
                                 i, $signed(out_sample), e);
                     end
                     done = 1'b1;
                  end
                  tick();
               end
               if (!done) begin
                  errors++; checks++;
                  $display("FAIL stream_timeout%0d: out_valid never seen, required 1", i);
               end
            end
            out_ready = 1'b0;
         end
      join
   endtask

   initial begin
      tick(); tick();
      rst_n = 1'b1;
      tick();
      test_reset();
      test_impulse();
      test_saturation();
      test_backpressure();
      test_clear();
      test_streaming();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
